// File: rtl/uarc_bus_scheduler.sv
// Round-robin arbiter driving one UARC bus port with a four-phase strobe/ack handshake.
// Optional ack-wait timeout is compiled in with `UARC_BUS_TIMEOUT_EN.
module uarc_bus_scheduler #(
   parameter int  WORD_MAG       = 5,
   parameter int  TOTAL_BUSES    = 1,
   parameter int  REQUESTERS     = 2,
   parameter int  TIMEOUT_CYCLES = 255,
   localparam int WORD_WIDTH     = 1 << WORD_MAG,
   localparam int BUS_SEL_WIDTH  = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [REQUESTERS-1:0]                 req_valid,
   input  logic [REQUESTERS*2-1:0]               req_op,
   input  logic [REQUESTERS*BUS_SEL_WIDTH-1:0]   req_bus,
   input  logic [REQUESTERS*WORD_WIDTH-1:0]      req_data,
   output logic [REQUESTERS-1:0]                 req_done,
   output logic [REQUESTERS-1:0]                 req_err,
   output logic                                  global_kill,
   output logic                                  global_incept,
   output logic                                  global_send,
   output logic                                  global_stream,
   output logic [WORD_WIDTH-1:0]                 global_data,
   output logic [TOTAL_BUSES-1:0]                sender_enables,
   input  logic [TOTAL_BUSES-1:0]                sender_kill_acks,
   input  logic [TOTAL_BUSES-1:0]                sender_incept_acks,
   input  logic [TOTAL_BUSES-1:0]                sender_send_acks,
   input  logic [TOTAL_BUSES-1:0]                sender_stream_acks,
   output logic                                  busy
);
   localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

   state_t                   state_q, state_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d, win_q, win_d, grant_idx;
   logic                     grant_found;
   logic [1:0]               op_q, op_d, sel_op;
   logic [BUS_SEL_WIDTH-1:0] bus_q, bus_d, sel_bus;
   logic [WORD_WIDTH-1:0]    sel_data, gdata_q, gdata_d;
   logic [3:0]               strobe_q, strobe_d;
   logic [TOTAL_BUSES-1:0]   en_q, en_d;
   logic [REQUESTERS-1:0]    done_q, done_d, err_q, err_d;
   logic                     reject_q, reject_d, busy_q, busy_d;
   logic                     active_ack, finish, finish_err;
`ifdef UARC_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]         cnt_q, cnt_d;
`endif

   // First valid requester at or after the pointer, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (!grant_found && req_valid[(int'(ptr_q) + i) % REQUESTERS]) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'((int'(ptr_q) + i) % REQUESTERS);
         end
      end
   end

   assign sel_op   = req_op[int'(grant_idx)*2 +: 2];
   assign sel_bus  = req_bus[int'(grant_idx)*BUS_SEL_WIDTH +: BUS_SEL_WIDTH];
   assign sel_data = req_data[int'(grant_idx)*WORD_WIDTH +: WORD_WIDTH];

   always_comb begin
      active_ack = 1'b0;
      case (op_q)
         2'd0:    active_ack = sender_kill_acks[bus_q];
         2'd1:    active_ack = sender_incept_acks[bus_q];
         2'd2:    active_ack = sender_send_acks[bus_q];
         default: active_ack = sender_stream_acks[bus_q];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      op_d       = op_q;
      bus_d      = bus_q;
      gdata_d    = gdata_q;
      strobe_d   = strobe_q;
      en_d       = en_q;
      done_d     = '0;
      err_d      = '0;
      reject_d   = 1'b0;
      finish     = 1'b0;
      finish_err = 1'b0;
`ifdef UARC_BUS_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            // A grant is held off while a completion pulse is pending or showing,
            // so a requester still holding req_valid is not granted twice.
            if (reject_q) begin
               done_d[win_q] = 1'b1;
               err_d[win_q]  = 1'b1;
            end else if (grant_found && (done_q == '0)) begin
               win_d = grant_idx;
               op_d  = sel_op;
               bus_d = sel_bus;
               ptr_d = PTR_W'((int'(grant_idx) + 1) % REQUESTERS);
               if (int'(sel_bus) >= TOTAL_BUSES) begin
                  reject_d = 1'b1;
               end else begin
                  state_d  = ISSUE;
                  strobe_d = 4'b0001 << sel_op;
                  en_d     = TOTAL_BUSES'(1) << sel_bus;
                  gdata_d  = sel_data;
`ifdef UARC_BUS_TIMEOUT_EN
                  cnt_d    = '0;
`endif
               end
            end
         end
         ISSUE: begin
            if (active_ack) begin
               finish = 1'b1;
`ifdef UARC_BUS_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               finish     = 1'b1;
               finish_err = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
            if (finish) begin
               strobe_d      = '0;
               en_d          = '0;
               gdata_d       = '0;
               done_d[win_q] = 1'b1;
               err_d[win_q]  = finish_err;
               state_d       = RELEASE;
            end
         end
         RELEASE: begin
            if (!active_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         win_q    <= '0;
         op_q     <= '0;
         bus_q    <= '0;
         gdata_q  <= '0;
         strobe_q <= '0;
         en_q     <= '0;
         done_q   <= '0;
         err_q    <= '0;
         reject_q <= 1'b0;
         busy_q   <= 1'b0;
`ifdef UARC_BUS_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         op_q     <= op_d;
         bus_q    <= bus_d;
         gdata_q  <= gdata_d;
         strobe_q <= strobe_d;
         en_q     <= en_d;
         done_q   <= done_d;
         err_q    <= err_d;
         reject_q <= reject_d;
         busy_q   <= busy_d;
`ifdef UARC_BUS_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign global_kill    = strobe_q[0];
   assign global_incept  = strobe_q[1];
   assign global_send    = strobe_q[2];
   assign global_stream  = strobe_q[3];
   assign global_data    = gdata_q;
   assign sender_enables = en_q;
   assign req_done       = done_q;
   assign req_err        = err_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_uarc_bus_scheduler.sv
// Scoreboard bench for uarc_bus_scheduler: directed handshake cases plus randomized traffic
// against a bus responder; the timeout case is built only with `UARC_BUS_TIMEOUT_EN.
module tb_uarc_bus_scheduler;
   localparam int WM = 5;
   localparam int WW = 32;
   localparam int TB = 3;
   localparam int RQ = 2;
   localparam int BSW = 2;
   localparam int TO = 8;
   localparam int NRAND = 25;

   typedef struct {
      bit          err;
      bit          on_bus;
      logic [1:0]  op;
      logic [1:0]  bus;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [RQ-1:0]     req_valid;
   logic [RQ*2-1:0]   req_op;
   logic [RQ*BSW-1:0] req_bus;
   logic [RQ*WW-1:0]  req_data;
   logic [RQ-1:0]     req_done, req_err;
   logic global_kill, global_incept, global_send, global_stream, busy;
   logic [WW-1:0]     global_data;
   logic [TB-1:0]     sender_enables;
   logic [TB-1:0]     sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks;
   logic [TB-1:0]     man_ack[4];
   logic [TB-1:0]     hold_ack[4];
   logic [TB-1:0]     noise_ack[4];
   logic [3:0]        s;
   bit                resp_en;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[RQ][$];

   always #5 clk = ~clk;

   assign s = {global_stream, global_send, global_incept, global_kill};
   assign sender_kill_acks   = man_ack[0] | hold_ack[0] | noise_ack[0];
   assign sender_incept_acks = man_ack[1] | hold_ack[1] | noise_ack[1];
   assign sender_send_acks   = man_ack[2] | hold_ack[2] | noise_ack[2];
   assign sender_stream_acks = man_ack[3] | hold_ack[3] | noise_ack[3];

   uarc_bus_scheduler #(.WORD_MAG(WM), .TOTAL_BUSES(TB), .REQUESTERS(RQ), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_bus(req_bus),
      .req_data(req_data), .req_done(req_done), .req_err(req_err), .global_kill(global_kill),
      .global_incept(global_incept), .global_send(global_send), .global_stream(global_stream),
      .global_data(global_data), .sender_enables(sender_enables),
      .sender_kill_acks(sender_kill_acks), .sender_incept_acks(sender_incept_acks),
      .sender_send_acks(sender_send_acks), .sender_stream_acks(sender_stream_acks), .busy(busy));

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int idx_of(input logic [31:0] v);
      for (int i = 0; i < 32; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Reference arbitration: first requester in mask at or after ptr, wrapping.
   function automatic int rr_pick(input int ptr, input logic [RQ-1:0] mask);
      for (int i = 0; i < RQ; i++) if (mask[(ptr + i) % RQ]) return (ptr + i) % RQ;
      return -1;
   endfunction

   task automatic drive_req(input int r, input logic [1:0] op, input logic [1:0] bus,
                            input logic [31:0] data, input bit tmo);
      exp_t e;
      e.on_bus = int'(bus) < TB;
      e.err    = !e.on_bus || tmo;
      e.op     = op;
      e.bus    = bus;
      e.data   = data;
      exp_q[r].push_back(e);
      req_op[r*2 +: 2]       = op;
      req_bus[r*BSW +: BSW]  = bus;
      req_data[r*WW +: WW]   = data;
      req_valid[r]           = 1'b1;
      $display("req r=%0d op=%0d bus=%0d data=%08h err_exp=%0d", r, op, bus, data, e.err);
   endtask

   task automatic wait_strobe(input int o, input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (s[o]) begin ok = 1'b1; break; end
      end
      chk(ok, nm, 64'(s), 64'(1 << o));
   endtask

   task automatic wait_done(input int r, input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (req_done[r]) begin ok = 1'b1; req_valid[r] = 1'b0; break; end
      end
      chk(ok, nm, 64'(req_done), 64'(1 << r));
   endtask

   task automatic wait_idle(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      chk(ok, nm, 64'(busy), 64'(0));
   endtask

   // Bus responder: acks the strobed op on the enabled bus after a random delay,
   // releases after the strobe drops, and toggles unrelated acks as noise.
   initial begin
      bit up = 1'b0;
      int dly = 0;
      int cur_o = 0, cur_b = 0;
      for (int o = 0; o < 4; o++) begin hold_ack[o] = '0; noise_ack[o] = '0; end
      forever begin
         @(negedge clk);
         if (!resp_en || !reset) begin
            up = 1'b0; dly = 0;
            for (int o = 0; o < 4; o++) begin hold_ack[o] = '0; noise_ack[o] = '0; end
         end else begin
            if (s != 0 && sender_enables != 0) begin
               cur_o = idx_of(32'(s));
               cur_b = idx_of(32'(sender_enables));
            end
            if (!up) begin
               if (s != 0 && sender_enables != 0) begin
                  if (dly == 0) begin
                     hold_ack[cur_o][cur_b] = 1'b1; up = 1'b1; dly = $urandom_range(0, 2);
                  end else dly--;
               end
            end else if (s == 0) begin
               if (dly == 0) begin
                  hold_ack[cur_o][cur_b] = 1'b0; up = 1'b0; dly = $urandom_range(0, 2);
               end else dly--;
            end
            for (int o = 0; o < 4; o++)
               for (int b = 0; b < TB; b++)
                  noise_ack[o][b] = busy && !(o == cur_o && b == cur_b) && ($urandom_range(0, 3) == 0);
         end
      end
   end

   // Monitor: protocol checks every cycle, captures bus transactions, pops the scoreboard on req_done.
   initial begin
      bit in_tx = 1'b0, obs_v = 1'b0;
      logic [1:0] obs_op, obs_bus;
      logic [31:0] obs_data;
      logic [RQ-1:0] prev_done = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            for (int r = 0; r < RQ; r++) exp_q[r].delete();
            in_tx = 1'b0; obs_v = 1'b0; prev_done = '0;
         end else begin
            chk(($countones(s) <= 1) && ((s != 0) == (sender_enables != 0)) &&
                (s == 0 || $countones(sender_enables) == 1) && (s != 0 || global_data == 0),
                "strobe_enable_consistency", {32'(s), 32'(sender_enables)}, 64'(0));
            if (s != 0) begin
               if (!in_tx) begin
                  in_tx = 1'b1; obs_v = 1'b1;
                  obs_op = 2'(idx_of(32'(s)));
                  obs_bus = 2'(idx_of(32'(sender_enables)));
                  obs_data = global_data;
                  $display("bus op=%0d bus=%0d data=%08h", obs_op, obs_bus, obs_data);
               end else begin
                  chk(global_data == obs_data && obs_op == 2'(idx_of(32'(s))) && busy,
                      "strobe_hold_stable", 64'(global_data), 64'(obs_data));
               end
            end else in_tx = 1'b0;
            chk(($countones(req_done) <= 1) && ((req_done & prev_done) == 0) && ((req_err & ~req_done) == 0),
                "done_pulse_shape", {32'(req_done), 32'(req_err)}, 64'(0));
            for (int r = 0; r < RQ; r++) begin
               if (req_done[r]) begin
                  chk(exp_q[r].size() != 0, "done_expected", 64'(r), 64'(0));
                  if (exp_q[r].size() != 0) begin
                     e = exp_q[r].pop_front();
                     $display("done r=%0d err=%0d", r, req_err[r]);
                     chk(req_err[r] == e.err, "req_err_value", 64'(req_err[r]), 64'(e.err));
                     chk(obs_v == e.on_bus, "bus_activity", 64'(obs_v), 64'(e.on_bus));
                     if (e.on_bus)
                        chk(obs_op == e.op && obs_bus == e.bus && obs_data == e.data, "bus_payload",
                            {obs_op, obs_bus, 28'd0, obs_data}, {e.op, e.bus, 28'd0, e.data});
                  end
                  obs_v = 1'b0;
               end
            end
            prev_done = req_done;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[$];
      int ptr_m, w, n;
      int issued[RQ], gap[RQ];
      bit act[RQ];
      bit finished;
      logic [1:0] r_op, r_bus;
      reset = 1'b0; resp_en = 1'b0;
      req_valid = '0; req_op = '0; req_bus = '0; req_data = '0;
      for (int o = 0; o < 4; o++) man_ack[o] = '0;
      repeat (3) @(negedge clk);
      chk({req_done, req_err, s, sender_enables, global_data, busy} == 0, "reset_outputs",
          {req_done, req_err, s, sender_enables, busy}, 64'(0));
      reset = 1'b1;
      @(negedge clk);

      // Single send with late ack; winner's inputs change after grant.
      drive_req(0, 2'd2, 2'd0, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      chk(global_send && sender_enables == 3'b001 && global_data == 32'hDEADBEEF && busy,
          "grant_timing", {32'(s), global_data}, {32'(4), 32'hDEADBEEF});
      req_data[31:0] = '0; req_op[1:0] = 2'd0; req_bus[1:0] = 2'd1;
      repeat (2) @(negedge clk);
      chk(global_send && global_data == 32'hDEADBEEF && !req_done[0], "latched_inputs",
          {32'(s), global_data}, {32'(4), 32'hDEADBEEF});
      man_ack[2][0] = 1'b1;
      @(negedge clk);
      chk(req_done[0] && !req_err[0], "ack_to_done", 64'(req_done), 64'(1));
      chk(s == 0 && sender_enables == 0 && global_data == 0, "ack_drops_outputs", 64'(s), 64'(0));
      req_valid[0] = 1'b0;
      man_ack[2][0] = 1'b0;
      wait_idle("single_send_idle");

      // Incept on bus 0 must ignore acks of other ops and other buses.
      drive_req(1, 2'd1, 2'd0, 32'h1234_5678, 1'b0);
      wait_strobe(1, "incept_grant");
      man_ack[2][0] = 1'b1; man_ack[1][1] = 1'b1; man_ack[3][0] = 1'b1;
      repeat (4) @(negedge clk);
      chk(global_incept && busy && req_done == 0, "wrong_ack_ignored", 64'(s), 64'(2));
      man_ack[2][0] = 1'b0; man_ack[1][1] = 1'b0; man_ack[3][0] = 1'b0;
      man_ack[1][0] = 1'b1;
      wait_done(1, "incept_done");
      repeat (2) @(negedge clk);
      chk(busy == 1'b1, "release_waits_ack_low", 64'(busy), 64'(1));
      man_ack[1][0] = 1'b0;
      wait_idle("incept_idle");

      // Out-of-range bus is rejected one cycle after grant with no bus activity.
      begin
         int done_at = 0;
         bit bus_seen = 1'b0;
         drive_req(0, 2'd3, 2'd3, 32'hBAD0_0003, 1'b0);
         for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (s != 0 || sender_enables != 0) bus_seen = 1'b1;
            if (req_done[0] && done_at == 0) begin done_at = i; req_valid[0] = 1'b0; end
         end
         chk(done_at == 2, "reject_timing", 64'(done_at), 64'(2));
         chk(!bus_seen, "reject_no_bus", 64'(bus_seen), 64'(0));
      end

      // Round robin with both requesters continuously valid, starting from a fresh pointer.
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      resp_en = 1'b1;
      n = 0;
      drive_req(0, 2'd2, 2'd1, $urandom, 1'b0);
      drive_req(1, 2'd3, 2'd2, $urandom, 1'b0);
      for (int c = 0; c < 400 && req_valid != 0; c++) begin
         @(negedge clk);
         for (int r = 0; r < RQ; r++) begin
            if (req_done[r]) begin
               order.push_back(r);
               n++;
               if (n < 4) drive_req(r, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), $urandom, 1'b0);
               else req_valid[r] = 1'b0;
            end
         end
      end
      chk(order.size() >= 4, "rr_count", 64'(order.size()), 64'(4));
      ptr_m = 0;
      for (int k = 0; k < 4 && k < order.size(); k++) begin
         w = rr_pick(ptr_m, 2'b11);
         $display("rr grant %0d: got=%0d want=%0d", k, order[k], w);
         chk(order[k] == w, "rr_order", 64'(order[k]), 64'(w));
         ptr_m = (w + 1) % RQ;
      end
      wait_idle("rr_idle");

      // Asynchronous reset in the middle of a stream transaction.
      resp_en = 1'b0;
      drive_req(0, 2'd3, 2'd2, 32'h5EA0_0001, 1'b0);
      wait_strobe(3, "stream_grant");
      @(posedge clk);
      #2 reset = 1'b0;
      #1 chk({req_done, req_err, s, sender_enables, global_data, busy} == 0, "async_reset_clear",
             {req_done, req_err, s, sender_enables, busy}, 64'(0));
      req_valid = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      resp_en = 1'b1;
      drive_req(1, 2'd0, 2'd1, 32'h0000_1111, 1'b0);
      drive_req(0, 2'd1, 2'd0, 32'h0000_2222, 1'b0);
      order.delete();
      for (int c = 0; c < 200 && req_valid != 0; c++) begin
         @(negedge clk);
         for (int r = 0; r < RQ; r++)
            if (req_done[r]) begin order.push_back(r); req_valid[r] = 1'b0; end
      end
      w = rr_pick(0, 2'b11);
      chk(order.size() == 2 && order[0] == w, "pointer_after_reset",
          64'(order.size() > 0 ? order[0] : -1), 64'(w));
      wait_idle("post_reset_idle");

      // Randomized traffic from both requesters, including out-of-range buses.
      for (int r = 0; r < RQ; r++) begin issued[r] = 0; gap[r] = 0; act[r] = 1'b0; end
      finished = 1'b0;
      for (int c = 0; c < 6000 && !finished; c++) begin
         @(negedge clk);
         for (int r = 0; r < RQ; r++) begin
            if (act[r]) begin
               if (req_done[r]) begin act[r] = 1'b0; req_valid[r] = 1'b0; gap[r] = $urandom_range(0, 3); end
            end else if (issued[r] < NRAND) begin
               if (gap[r] > 0) gap[r]--;
               else begin
                  r_op = 2'($urandom_range(0, 3));
                  r_bus = 2'($urandom_range(0, 3));
                  drive_req(r, r_op, r_bus, $urandom, 1'b0);
                  issued[r]++;
                  act[r] = 1'b1;
               end
            end
         end
         finished = (issued[0] == NRAND) && (issued[1] == NRAND) && !act[0] && !act[1];
      end
      chk(finished, "random_complete", 64'(issued[0] + issued[1]), 64'(2 * NRAND));
      wait_idle("random_idle");
      resp_en = 1'b0;

`ifdef UARC_BUS_TIMEOUT_EN
      begin
         int hi = 0;
         bit got = 1'b0;
         drive_req(0, 2'd2, 2'd1, 32'hCAFE_0001, 1'b1);
         for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (global_send) hi++;
            if (req_done[0]) begin got = 1'b1; req_valid[0] = 1'b0; end
         end
         chk(got && hi == TO, "timeout_cycles", 64'(hi), 64'(TO));
         chk(s == 0 && req_err[0], "timeout_drops_strobe", 64'(s), 64'(0));
         wait_idle("timeout_idle");
      end
`endif

      repeat (4) @(negedge clk);
      chk(exp_q[0].size() == 0 && exp_q[1].size() == 0, "scoreboard_drained",
          64'(exp_q[0].size() + exp_q[1].size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
